subtractor_16_seq: RTL and testbench

//   Multi-cycle 16-bit subtractor; computes diff = a - b at STEP bits per cycle.

---
 rtl/subtractor_16_seq_if.sv | 39 +++
 rtl/subtractor_16_seq.sv | 147 ++++++++++++++
 tb/tb_subtractor_16_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/subtractor_16_seq_if.sv
// Operand/result handshake bundle for subtractor_16_seq.
// SUB16_COMPARE_EN adds the zero / lt_u / lt_s compare outputs.
interface subtractor_16_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             sign;
  logic             parity;
  logic             overflow;
  logic             borrow;
`ifdef SUB16_COMPARE_EN
  logic             zero;
  logic             lt_u;
  logic             lt_s;
`endif

  // master: operand issuer and result consumer
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, sign, parity, overflow, borrow
`ifdef SUB16_COMPARE_EN
    , input zero, lt_u, lt_s
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, sign, parity, overflow, borrow
`ifdef SUB16_COMPARE_EN
    , output zero, lt_u, lt_s
`endif
  );
endinterface

// File: rtl/subtractor_16_seq.sv
// Multi-cycle subtractor: diff = a - b computed as a + ~b + 1, STEP bits per cycle.
// Optional compare outputs (zero, lt_u, lt_s) when SUB16_COMPARE_EN is defined.
module subtractor_16_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  subtractor_16_seq_if.slave   bus
);
  localparam int NSLICE = WIDTH / STEP;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, nb_reg, diff_reg, diff_next;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               in_ready_reg, out_valid_reg;
  logic               sign_reg, parity_reg, overflow_reg, borrow_reg;
  logic               accept, last_slice;

  logic [STEP-1:0]    sa, sb, g, p, sum;
  logic [STEP:0]      c;

  // Carry into bit n+1 expanded as a flat generate/propagate sum of products.
  function automatic logic cla_carry(input logic [STEP-1:0] gg, input logic [STEP-1:0] pp,
                                     input logic cin, input int n);
    logic cy, prop;
    cy   = 1'b0;
    prop = 1'b1;
    for (int j = n; j >= 0; j--) begin
      cy   = cy | (prop & gg[j]);
      prop = prop & pp[j];
    end
    return cy | (prop & cin);
  endfunction

  assign accept     = (state_reg == IDLE) && in_ready_reg && bus.in_valid;
  assign last_slice = (idx_reg == IDX_W'(NSLICE - 1));

  assign sa   = a_reg[idx_reg*STEP +: STEP];
  assign sb   = nb_reg[idx_reg*STEP +: STEP];
  assign c[0] = carry_reg;

  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_cla
      assign g[gi]    = sa[gi] & sb[gi];
      assign p[gi]    = sa[gi] ^ sb[gi];
      assign c[gi+1]  = cla_carry(g, p, carry_reg, gi);
      assign sum[gi]  = p[gi] ^ c[gi];
    end
  endgenerate

  always_comb begin
    diff_next = diff_reg;
    diff_next[idx_reg*STEP +: STEP] = sum;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (last_slice) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

`ifdef SUB16_COMPARE_EN
  logic zero_reg, lt_u_reg, lt_s_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg         <= '0;
      nb_reg        <= '0;
      diff_reg      <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      sign_reg      <= 1'b0;
      parity_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      borrow_reg    <= 1'b0;
`ifdef SUB16_COMPARE_EN
      zero_reg      <= 1'b0;
      lt_u_reg      <= 1'b0;
      lt_s_reg      <= 1'b0;
`endif
    end else begin
      in_ready_reg  <= (state_next == IDLE);
      out_valid_reg <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.a;
            nb_reg    <= ~bus.b;
            carry_reg <= 1'b1;
            idx_reg   <= '0;
          end
        end
        CALC: begin
          diff_reg  <= diff_next;
          carry_reg <= c[STEP];
          idx_reg   <= idx_reg + IDX_W'(1);
          // Flags take the full result including the slice written this edge.
          if (last_slice) begin
            sign_reg     <= diff_next[WIDTH-1];
            parity_reg   <= ~^diff_next;
            overflow_reg <= (a_reg[WIDTH-1] == nb_reg[WIDTH-1]) &&
                            (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
            borrow_reg   <= ~c[STEP];
`ifdef SUB16_COMPARE_EN
            zero_reg     <= (diff_next == '0);
            lt_u_reg     <= ~c[STEP];
            lt_s_reg     <= diff_next[WIDTH-1] ^
                            ((a_reg[WIDTH-1] == nb_reg[WIDTH-1]) &&
                             (diff_next[WIDTH-1] != a_reg[WIDTH-1]));
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.sign      = sign_reg;
  assign bus.parity    = parity_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.borrow    = borrow_reg;
`ifdef SUB16_COMPARE_EN
  assign bus.zero      = zero_reg;
  assign bus.lt_u      = lt_u_reg;
  assign bus.lt_s      = lt_s_reg;
`endif
endmodule

// File: tb/tb_subtractor_16_seq.sv
// Directed bench for subtractor_16_seq: hand-computed vectors, backpressure and reset abort.
module tb_subtractor_16_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks_passed = 0;
  int   checks_total  = 0;
  int   lat;

  always #5 clk = ~clk;

  subtractor_16_seq_if #(.WIDTH(16)) bus ();

  subtractor_16_seq #(.WIDTH(16), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] d, input logic s,
                               input logic par, input logic ov, input logic br,
                               input logic z, input logic lu, input logic ls);
    check({tag, ".diff"},     32'(bus.diff),     32'(d));
    check({tag, ".sign"},     32'(bus.sign),     32'(s));
    check({tag, ".parity"},   32'(bus.parity),   32'(par));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(ov));
    check({tag, ".borrow"},   32'(bus.borrow),   32'(br));
`ifdef SUB16_COMPARE_EN
    check({tag, ".zero"},     32'(bus.zero),     32'(z));
    check({tag, ".lt_u"},     32'(bus.lt_u),     32'(lu));
    check({tag, ".lt_s"},     32'(bus.lt_s),     32'(ls));
`endif
    $display("%s: diff=%04h s=%0b p=%0b o=%0b b=%0b (exp z/lu/ls=%0b%0b%0b)",
             tag, bus.diff, bus.sign, bus.parity, bus.overflow, bus.borrow, z, lu, ls);
  endtask

  task automatic wait_result(input string tag);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd4);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] d, input logic s, input logic par,
                        input logic ov, input logic br,
                        input logic z, input logic lu, input logic ls);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    check({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
    wait_result(tag);
    check_outputs(tag, d, s, par, ov, br, z, lu, ls);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 16'h0;
    bus.b = 16'h0;

    // Reset state
    tick();
    tick();
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_outputs("rst", 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("rel.in_ready", 32'(bus.in_ready), 32'd1);

    run_op("t1",  16'h0005, 16'h0003, 16'h0002, 0, 0, 0, 0, 0, 0, 0);
    run_op("t2",  16'h0000, 16'h0001, 16'hFFFF, 1, 1, 0, 1, 0, 1, 1);
    run_op("t3",  16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, 0, 0, 0, 1);
    run_op("t4",  16'h7FFF, 16'hFFFF, 16'h8000, 1, 0, 1, 1, 0, 1, 0);
    run_op("t4z", 16'h1234, 16'h1234, 16'h0000, 0, 1, 0, 0, 1, 0, 0);
    run_op("t4b", 16'h1234, 16'h5678, 16'hBBBC, 1, 0, 0, 1, 0, 1, 1);
    run_op("t4c", 16'hFFFF, 16'h0001, 16'hFFFE, 1, 0, 0, 0, 0, 0, 1);

    // Backpressure in DONE with new operands offered
    bus.a = 16'h0005;
    bus.b = 16'h0003;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_result("t5");
    bus.a = 16'h1111;
    bus.b = 16'h0001;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5.hold_valid", 32'(bus.out_valid), 32'd1);
      check("t5.hold_diff", 32'(bus.diff), 32'h0002);
      check("t5.hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t5.drop", 32'(bus.out_valid), 32'd0);
    check("t5.idle", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    wait_result("t5n");
    check_outputs("t5n", 16'h1110, 0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset during the second CALC cycle aborts the operation
    bus.a = 16'hFFFF;
    bus.b = 16'h0000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("t6.in_ready", 32'(bus.in_ready), 32'd0);
    check("t6.out_valid", 32'(bus.out_valid), 32'd0);
    check_outputs("t6", 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("t6.rel_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6.no_result", 32'(bus.out_valid), 32'd0);
    end
    run_op("t6r", 16'h0005, 16'h0003, 16'h0002, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
